// File: rtl/fetch_stage.sv
// Instruction fetch: PC, two-word assembly, branch flush into the IF/ID slot.
// Optional interrupt entry is built when INTERRUPT_EN is defined.
module fetch_stage #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
  parameter logic [31:0] INT_VECTOR   = 32'h0000_0002,
  parameter int          IMM_BIT      = 0
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_branch_decision,
  input  logic [31:0] i_pc_new,
  input  logic [15:0] i_imem_data,
`ifdef INTERRUPT_EN
  input  logic        i_interrupt,
  output logic        o_int_ack,
`endif
  output logic [31:0] o_imem_addr,
  output logic [15:0] o_instr,
  output logic [15:0] o_immediate,
  output logic [31:0] o_pc,
  output logic [31:0] o_pc_next,
  output logic        o_valid
);

  localparam logic S_FETCH = 1'b0;
  localparam logic S_IMM   = 1'b1;

  logic        state;
  logic [31:0] pc;
  logic [31:0] pc_inc;
  logic [15:0] held;
  logic        irq_take;

  assign o_imem_addr = pc;
  assign pc_inc      = pc + 32'd1;

`ifdef INTERRUPT_EN
  logic irq_q;
  logic irq_pend;
  logic irq_req;

  // Entry only at an instruction boundary; a blocked request stays pending.
  assign irq_req  = irq_pend | (i_interrupt & ~irq_q);
  assign irq_take = irq_req & (state == S_FETCH)
                  & ~i_stall & ~i_branch_decision;

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      irq_q     <= 1'b0;
      irq_pend  <= 1'b0;
      o_int_ack <= 1'b0;
    end else begin
      irq_q     <= i_interrupt;
      irq_pend  <= irq_req & ~irq_take;
      o_int_ack <= irq_take;
    end
  end
`else
  assign irq_take = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      pc          <= RESET_VECTOR;
      state       <= S_FETCH;
      held        <= '0;
      o_instr     <= '0;
      o_immediate <= '0;
      o_pc        <= '0;
      o_pc_next   <= '0;
      o_valid     <= 1'b0;
    end else if (i_branch_decision) begin
      pc      <= i_pc_new;
      state   <= S_FETCH;
      o_valid <= 1'b0;
    end else if (i_stall) begin
      pc <= pc;
    end else if (irq_take) begin
      o_valid   <= 1'b0;
      o_pc_next <= pc;
      pc        <= INT_VECTOR;
    end else begin
      unique case (state)
        S_FETCH: begin
          if (i_imem_data[IMM_BIT]) begin
            held    <= i_imem_data;
            o_valid <= 1'b0;
            state   <= S_IMM;
          end else begin
            o_instr     <= i_imem_data;
            o_immediate <= '0;
            o_pc        <= pc;
            o_pc_next   <= pc_inc;
            o_valid     <= 1'b1;
          end
          pc <= pc_inc;
        end
        S_IMM: begin
          o_instr     <= held;
          o_immediate <= i_imem_data;
          o_pc        <= pc - 32'd1;
          o_pc_next   <= pc_inc;
          o_valid     <= 1'b1;
          pc          <= pc_inc;
          state       <= S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
